// File: rtl/ecc_pkg.sv
// Shared codes for the ECC operation sequencer: request modes, width codes,
// error-count codes, FSM state encoding and the width-to-mask helper.
package ecc_pkg;

  localparam logic [1:0] MODE_ENC  = 2'b00;
  localparam logic [1:0] MODE_DEC  = 2'b01;
  localparam logic [1:0] MODE_FULL = 2'b10;
  localparam logic [1:0] MODE_RSVD = 2'b11;

  localparam logic [1:0] WIDTH_8   = 2'b00;
  localparam logic [1:0] WIDTH_16  = 2'b01;
  localparam logic [1:0] WIDTH_32  = 2'b10;
  localparam logic [1:0] WIDTH_ILL = 2'b11;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_ONE   = 2'b01;
  localparam logic [1:0] ERR_TWO   = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ENC       = 3'd1,
    ST_NOISE_ADD = 3'd2,
    ST_DEC       = 3'd3,
    ST_DONE      = 3'd4
  } state_e;

  function automatic logic [31:0] width_mask(input logic [1:0] width);
    case (width)
      WIDTH_8:  width_mask = 32'h0000_00FF;
      WIDTH_16: width_mask = 32'h0000_FFFF;
      default:  width_mask = 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic req_legal(input logic [1:0] mode, input logic [1:0] width);
    req_legal = (mode != MODE_RSVD) && (width != WIDTH_ILL);
  endfunction

endpackage

// File: rtl/ecc_noise_mask.sv
// Channel noise injection: flips codeword bits selected by the noise pattern,
// restricted to the active codeword width.
module ecc_noise_mask
  import ecc_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] codeword_i,
  input  logic [W-1:0] noise_i,
  input  logic [1:0]   width_i,
  output logic [W-1:0] noisy_o
);

  logic [W-1:0] mask;

  assign mask    = W'(width_mask(width_i));
  assign noisy_o = codeword_i ^ (noise_i & mask);

endmodule

// File: rtl/ecc_op_sequencer.sv
// Sequences one encode / decode / full-channel operation on the ECC datapath.
// Optional per-phase dp_done timeout is enabled by defining ECC_SEQ_TIMEOUT_EN.
module ecc_op_sequencer
  import ecc_pkg::*;
#(
  parameter int AMBA_WORD      = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ctrl_wr,
  input  logic [AMBA_WORD-1:0] CTRL,
  input  logic [AMBA_WORD-1:0] DATA_IN,
  input  logic [AMBA_WORD-1:0] CODEWORD_WIDTH,
  input  logic [AMBA_WORD-1:0] NOISE,
  output logic                 dp_start,
  output logic                 dp_mode,
  output logic [1:0]           dp_width,
  output logic [AMBA_WORD-1:0] dp_data,
  input  logic                 dp_done,
  input  logic [AMBA_WORD-1:0] dp_result,
  input  logic [1:0]           dp_num_errors,
  output logic [AMBA_WORD-1:0] DATA_OUT,
  output logic [1:0]           NUM_OF_ERRORS,
  output logic                 operation_done,
  output logic                 busy,
  output logic                 op_error,
  output state_e               dbg_state_o
);

  // Datapath handshake: dp_start is a one-cycle request with no backpressure;
  // dp_done is a one-cycle response, honoured only while in ENC or DEC.
  state_e               state_q, state_d;
  logic [1:0]           mode_q, mode_d, width_q, width_d;
  logic [AMBA_WORD-1:0] op_q, op_d, noise_q, noise_d, data_out_q, data_out_d;
  logic [1:0]           nerr_q, nerr_d;
  logic                 done_q, done_d, err_q, err_d, first_q, first_d;
  logic                 waiting, timeout;
  logic [AMBA_WORD-1:0] noisy;
  logic                 unused_hi_bits;

  assign unused_hi_bits = ^{CTRL[AMBA_WORD-1:2], CODEWORD_WIDTH[AMBA_WORD-1:2]};
  assign waiting        = (state_q == ST_ENC) || (state_q == ST_DEC);

  ecc_noise_mask #(.W(AMBA_WORD)) u_noise (
    .codeword_i (op_q),
    .noise_i    (noise_q),
    .width_i    (width_q),
    .noisy_o    (noisy)
  );

`ifdef ECC_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign timeout = waiting && !dp_done && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (first_d)      cnt_d = '0;
    else if (waiting) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    width_d    = width_q;
    op_d       = op_q;
    noise_d    = noise_q;
    data_out_d = data_out_q;
    nerr_d     = nerr_q;
    done_d     = done_q;
    err_d      = err_q;
    case (state_q)
      ST_IDLE: begin
        if (ctrl_wr) begin
          if (req_legal(CTRL[1:0], CODEWORD_WIDTH[1:0])) begin
            mode_d  = CTRL[1:0];
            width_d = CODEWORD_WIDTH[1:0];
            op_d    = DATA_IN;
            noise_d = NOISE;
            done_d  = 1'b0;
            err_d   = 1'b0;
            state_d = (CTRL[1:0] == MODE_DEC) ? ST_DEC : ST_ENC;
          end else begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end
        end
      end
      ST_ENC: begin
        if (dp_done) begin
          if (mode_q == MODE_FULL) begin
            op_d    = dp_result;
            state_d = ST_NOISE_ADD;
          end else begin
            data_out_d = dp_result;
            nerr_d     = ERR_NONE;
            state_d    = ST_DONE;
          end
        end else if (timeout) begin
          data_out_d = '0;
          nerr_d     = ERR_NONE;
          err_d      = 1'b1;
          state_d    = ST_DONE;
        end
      end
      ST_NOISE_ADD: begin
        op_d    = noisy;
        state_d = ST_DEC;
      end
      ST_DEC: begin
        if (dp_done) begin
          data_out_d = dp_result;
          nerr_d     = dp_num_errors;
          state_d    = ST_DONE;
        end else if (timeout) begin
          data_out_d = '0;
          nerr_d     = ERR_NONE;
          err_d      = 1'b1;
          state_d    = ST_DONE;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ENC and DEC are never entered from each other, so any entry is a fresh phase.
  assign first_d = (state_d != state_q) && ((state_d == ST_ENC) || (state_d == ST_DEC));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      mode_q     <= '0;
      width_q    <= '0;
      op_q       <= '0;
      noise_q    <= '0;
      data_out_q <= '0;
      nerr_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      first_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      width_q    <= width_d;
      op_q       <= op_d;
      noise_q    <= noise_d;
      data_out_q <= data_out_d;
      nerr_q     <= nerr_d;
      done_q     <= done_d;
      err_q      <= err_d;
      first_q    <= first_d;
    end
  end

  assign dp_start       = first_q;
  assign dp_mode        = (state_q == ST_DEC);
  assign dp_width       = width_q;
  assign dp_data        = waiting ? op_q : '0;
  assign DATA_OUT       = data_out_q;
  assign NUM_OF_ERRORS  = nerr_q;
  assign operation_done = done_q;
  assign op_error       = err_q;
  assign busy           = (state_q != ST_IDLE);
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_ecc_op_sequencer.sv
// Scoreboard bench for ecc_op_sequencer with a toy datapath responder and a
// behavioural reference model of the operation rules.
module tb_ecc_op_sequencer;
  import ecc_pkg::*;

`ifdef ECC_SEQ_TIMEOUT_EN
  localparam int TO_CYC = 16;
`else
  localparam int TO_CYC = 1024;
`endif

  logic        clk = 1'b0;
  logic        rst, ctrl_wr, dp_start, dp_mode, dp_done;
  logic [31:0] CTRL, DATA_IN, CODEWORD_WIDTH, NOISE, dp_data, dp_result, DATA_OUT;
  logic [1:0]  dp_width, dp_num_errors, NUM_OF_ERRORS;
  logic        operation_done, busy, op_error;
  state_e      dbg_state;

  ecc_op_sequencer #(.AMBA_WORD(32), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk(clk), .rst(rst), .ctrl_wr(ctrl_wr), .CTRL(CTRL), .DATA_IN(DATA_IN),
    .CODEWORD_WIDTH(CODEWORD_WIDTH), .NOISE(NOISE), .dp_start(dp_start),
    .dp_mode(dp_mode), .dp_width(dp_width), .dp_data(dp_data), .dp_done(dp_done),
    .dp_result(dp_result), .dp_num_errors(dp_num_errors), .DATA_OUT(DATA_OUT),
    .NUM_OF_ERRORS(NUM_OF_ERRORS), .operation_done(operation_done), .busy(busy),
    .op_error(op_error), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  // result entry: {DATA_OUT[31:0], NUM_OF_ERRORS[1:0], op_error, completion cycle[31:0]}
  logic [66:0] exp_q[$];
  // start entry: {dp_mode, dp_width[1:0], dp_data[31:0]}
  logic [34:0] exp_start_q[$];

  // reference model state
  logic [31:0] m_out = '0, m_last_enc = '0;
  logic [1:0]  m_nerr = '0;

  // datapath stand-in state
  logic        dp_auto = 1'b1;
  logic [31:0] dp_last_cw = '0;

  function automatic logic [31:0] tb_enc(input logic [31:0] d);
    return d ^ 32'h0000_0100;
  endfunction

  function automatic logic [31:0] tb_dec(input logic [31:0] c);
    return c ^ 32'h0000_0100;
  endfunction

  function automatic logic [1:0] clip2(input int n);
    return (n >= 2) ? 2'd2 : 2'(n);
  endfunction

  function automatic logic [31:0] mask_of(input logic [1:0] w);
    logic [63:0] m;
    m = (64'd1 << (8 << w)) - 64'd1;
    return m[31:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [1:0] mode, input logic [1:0] w, input logic [31:0] d,
                       input logic [31:0] n, input bit push_res, output int unsigned ic);
    logic [31:0] r, cw, noisy;
    int unsigned lat;
    @(negedge clk);
    r = $urandom();
    CTRL = {r[31:2], mode};
    r = $urandom();
    CODEWORD_WIDTH = {r[31:2], w};
    DATA_IN = d;
    NOISE = n;
    ctrl_wr = 1'b1;
    ic = cyc + 1;
    if (mode == 2'b11 || w == 2'b11) begin
      exp_q.push_back({m_out, m_nerr, 1'b1, ic});
    end else begin
      case (mode)
        2'b00: begin
          cw = tb_enc(d);
          exp_start_q.push_back({1'b0, w, d});
          m_out = cw; m_nerr = 2'd0; m_last_enc = cw; lat = 3;
        end
        2'b10: begin
          cw = tb_enc(d);
          noisy = cw ^ (n & mask_of(w));
          exp_start_q.push_back({1'b0, w, d});
          exp_start_q.push_back({1'b1, w, noisy});
          m_out = tb_dec(noisy); m_nerr = clip2($countones(n & mask_of(w)));
          m_last_enc = cw; lat = 6;
        end
        default: begin
          exp_start_q.push_back({1'b1, w, d});
          m_out = tb_dec(d); m_nerr = clip2($countones(d ^ m_last_enc)); lat = 3;
        end
      endcase
      if (push_res) exp_q.push_back({m_out, m_nerr, 1'b0, ic + lat});
    end
    @(negedge clk);
    ctrl_wr = 1'b0;
    CTRL = $urandom(); DATA_IN = $urandom(); NOISE = $urandom(); CODEWORD_WIDTH = $urandom();
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || exp_start_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("completion_within_budget", 32'(n >= 200), 32'd0);
    if (n >= 200) begin
      exp_q.delete();
      exp_start_q.delete();
    end
    @(negedge clk);
    check("busy_after_op", 32'(busy), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_DATA_OUT"}, DATA_OUT, 32'd0);
    check({tag, "_NUM_OF_ERRORS"}, 32'(NUM_OF_ERRORS), 32'd0);
    check({tag, "_operation_done"}, 32'(operation_done), 32'd0);
    check({tag, "_op_error"}, 32'(op_error), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_dp_start"}, 32'(dp_start), 32'd0);
    check({tag, "_dp_mode"}, 32'(dp_mode), 32'd0);
    check({tag, "_dp_width"}, 32'(dp_width), 32'd0);
    check({tag, "_dp_data"}, dp_data, 32'd0);
    check({tag, "_state_idle"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  // ---------------- datapath responder ----------------
  initial begin
    logic        m;
    logic [31:0] c;
    forever begin
      @(negedge clk);
      if (dp_auto && dp_start) begin
        m = dp_mode;
        c = dp_data;
        @(negedge clk);
        dp_done = 1'b1;
        dp_result = m ? tb_dec(c) : tb_enc(c);
        dp_num_errors = m ? clip2($countones(c ^ dp_last_cw)) : 2'd0;
        if (!m) dp_last_cw = tb_enc(c);
        @(negedge clk);
        dp_done = 1'b0;
        dp_result = $urandom();
        dp_num_errors = 2'($urandom_range(0, 3));
      end
    end
  end

  // ---------------- monitors ----------------
  initial begin
    logic [34:0] e;
    forever begin
      @(negedge clk);
      if (dp_start) begin
        if (exp_start_q.size() == 0) begin
          check("unexpected_dp_start", 32'(dp_start), 32'd0);
        end else begin
          e = exp_start_q.pop_front();
          check("dp_mode", 32'(dp_mode), 32'(e[34]));
          check("dp_width", 32'(dp_width), 32'(e[33:32]));
          check("dp_data", dp_data, e[31:0]);
        end
      end
    end
  end

  initial begin
    logic        done_prev = 1'b0, err_prev = 1'b0, resp;
    logic [66:0] e;
    forever begin
      @(negedge clk);
      resp = operation_done && (!done_prev || (op_error && !err_prev));
      if (resp) begin
        if (exp_q.size() == 0) begin
          check("unexpected_completion", 32'(resp), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("DATA_OUT", DATA_OUT, e[66:35]);
          check("NUM_OF_ERRORS", 32'(NUM_OF_ERRORS), 32'(e[34:33]));
          check("op_error", 32'(op_error), 32'(e[32]));
          check("done_cycle", cyc, e[31:0]);
          check("busy_at_done", 32'(busy), 32'd0);
        end
      end
      done_prev = operation_done;
      err_prev = op_error;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int unsigned ic;
    logic [31:0] d, n, saved;
    logic [1:0]  mode, w;
    bit          prev_illegal;

    rst = 1'b0; ctrl_wr = 1'b0; CTRL = '0; DATA_IN = '0; CODEWORD_WIDTH = '0; NOISE = '0;
    dp_done = 1'b0; dp_result = '0; dp_num_errors = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;

    // directed encode, illegal mode, full channel, illegal width
    issue(2'b00, 2'b00, 32'h0000_00A5, 32'h0, 1'b1, ic);
    wait_idle();
    check("encode_A5_result", DATA_OUT, 32'h0000_01A5);
    issue(2'b11, 2'b00, 32'h1111_1111, 32'h0, 1'b1, ic);
    wait_idle();
    issue(2'b10, 2'b01, 32'h0000_1234, 32'hFFFF_0004, 1'b1, ic);
    wait_idle();
    check("full_1234_nerr", 32'(NUM_OF_ERRORS), 32'd1);
    issue(2'b01, 2'b11, 32'h2222_2222, 32'h0, 1'b1, ic);
    wait_idle();

    // write while busy in DEC must not disturb the operation
    d = $urandom(); n = $urandom(); w = 2'($urandom_range(0, 2));
    issue(2'b10, w, d, n, 1'b1, ic);
    repeat (3) @(negedge clk);
    CTRL = 32'h0; DATA_IN = ~d; ctrl_wr = 1'b1;
    @(negedge clk);
    ctrl_wr = 1'b0;
    check("busy_dp_data_held", dp_data, tb_enc(d) ^ (n & mask_of(w)));
    check("busy_flag_in_dec", 32'(busy), 32'd1);
    wait_idle();

    // reset during ENC, followed by a late dp_done
    dp_auto = 1'b0;
    saved = m_last_enc;
    issue(2'b00, 2'b10, $urandom(), $urandom(), 1'b0, ic);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    dp_done = 1'b1; dp_result = 32'hDEAD_BEEF; dp_num_errors = 2'b01;
    @(negedge clk);
    dp_done = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset_mid_op");
    m_last_enc = saved; m_out = '0; m_nerr = '0;

`ifdef ECC_SEQ_TIMEOUT_EN
    issue(2'b00, 2'b01, $urandom(), $urandom(), 1'b0, ic);
    exp_q.push_back({32'd0, 2'b00, 1'b1, ic + 32'd17});
    m_last_enc = saved; m_out = '0; m_nerr = '0;
    wait_idle();
`else
    d = $urandom();
    issue(2'b00, 2'b01, d, $urandom(), 1'b0, ic);
    repeat (40) @(negedge clk);
    check("wait_busy_held", 32'(busy), 32'd1);
    check("wait_no_done", 32'(operation_done), 32'd0);
    dp_done = 1'b1; dp_result = tb_enc(d); dp_num_errors = 2'b00;
    dp_last_cw = tb_enc(d);
    exp_q.push_back({tb_enc(d), 2'b00, 1'b0, cyc + 32'd2});
    @(negedge clk);
    dp_done = 1'b0;
    wait_idle();
`endif
    dp_auto = 1'b1;

    // randomized operations
    prev_illegal = 1'b1;
    for (int i = 0; i < 40; i++) begin
      mode = 2'($urandom_range(0, 3));
      w = 2'($urandom_range(0, 3));
      if (prev_illegal && (mode == 2'b11 || w == 2'b11)) begin
        mode = 2'($urandom_range(0, 2));
        w = 2'($urandom_range(0, 2));
      end
      prev_illegal = (mode == 2'b11 || w == 2'b11);
      issue(mode, w, $urandom(), $urandom(), 1'b1, ic);
      wait_idle();
      if ($urandom_range(0, 3) == 0) begin
        dp_done = 1'b1; dp_result = $urandom(); dp_num_errors = 2'b10;
        @(negedge clk);
        dp_done = 1'b0;
        @(negedge clk);
        check("stray_dp_done_ignored", DATA_OUT, m_out);
        check("stray_dp_done_idle", 32'(busy), 32'd0);
      end
    end

    repeat (5) @(negedge clk);
    check("leftover_results", exp_q.size(), 32'd0);
    check("leftover_starts", exp_start_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ecc_op_sequencer.md
Name: ecc_op_sequencer

Overview:
- Sequences one encode, decode or full-channel operation on the ECC encoder/decoder datapath.
- Operations are triggered by CPU writes to the CTRL register.
- Sits between the APB register file (which supplies CTRL, DATA_IN, CODEWORD_WIDTH, NOISE and a CTRL-write strobe) and the enc/dec core.
- Returns DATA_OUT, NUM_OF_ERRORS and operation_done to the top level.

Parameters:
- AMBA_WORD, 32, register/data width.
- TIMEOUT_CYCLES, 1024, max cycles to wait for dp_done per datapath phase.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-low reset
- ctrl_wr  input  1  one-cycle pulse: CTRL register was written this cycle
- CTRL  input  AMBA_WORD  bits[1:0] = mode: 00 encode, 01 decode, 10 full channel, 11 reserved
- DATA_IN  input  AMBA_WORD  operand
- CODEWORD_WIDTH  input  AMBA_WORD  bits[1:0] = width: 00→8, 01→16, 10→32, 11 illegal
- NOISE  input  AMBA_WORD  error pattern for full channel
- dp_start  output  1  one-cycle start pulse to datapath
- dp_mode  output  1  0 = encode, 1 = decode
- dp_width  output  2  latched width code
- dp_data  output  AMBA_WORD  datapath operand
- dp_done  input  1  one-cycle pulse: dp_result/dp_num_errors valid
- dp_result  input  AMBA_WORD  codeword (encode) or data (decode)
- dp_num_errors  input  2  00 none, 01 one corrected, 10 two detected
- DATA_OUT  output  AMBA_WORD  operation result
- NUM_OF_ERRORS  output  2  error count of last decode
- operation_done  output  1  level: last operation finished
- busy  output  1  FSM not IDLE
- op_error  output  1  illegal request or timeout on last operation

Behaviour:
- Reset: every register is sampled on the rising clk edge with rst=0. This includes the FSM, which goes to IDLE. All outputs are 0.
- States: IDLE, ENC, NOISE_ADD, DEC, DONE.
- Start acceptance (IDLE only):
  - Trigger: ctrl_wr=1 with mode≠11 and width≠11.
  - On the accepting edge: latch mode, width, DATA_IN and NOISE into shadow registers; clear operation_done and op_error.
  - Next state: ENC for mode 00/10, DEC for mode 01.
  - Later register writes do not affect an in-flight operation.
- Illegal request in IDLE (mode 11 or width 11): stay IDLE; set op_error=1 and operation_done=1 next cycle; DATA_OUT unchanged.
- ctrl_wr while busy: ignored. No queueing, no error.
- ENC/DEC:
  - dp_start=1 only in the first cycle of the state.
  - dp_mode=0 in ENC, 1 in DEC; dp_width = latched width.
  - dp_data in ENC = latched DATA_IN.
  - dp_data in DEC = latched DATA_IN (mode 01), or the noisy codeword (mode 10).
  - State held until dp_done=1.
- On dp_done in ENC:
  - mode 00 → DONE with DATA_OUT=dp_result, NUM_OF_ERRORS=00.
  - mode 10 → NOISE_ADD; store dp_result.
- NOISE_ADD, 1 cycle: codeword ^= (NOISE & mask); mask = 0xFF / 0xFFFF / 0xFFFFFFFF per width. Next state DEC.
- On dp_done in DEC → DONE with DATA_OUT=dp_result, NUM_OF_ERRORS=dp_num_errors.
- DONE, 1 cycle: operation_done set to 1 (held until next accepted start); next state IDLE.
- Latency, datapath done in 1 cycle:
  - encode: ctrl_wr edge to operation_done high = 3 cycles.
  - full channel: 6 cycles.
- dp_done outside ENC/DEC: ignored.
- busy=1 in all states except IDLE.
- Reset mid-operation: abort immediately and return to IDLE with outputs cleared. A dp_done arriving afterwards is ignored.

Optional Feature:
- Macro: ECC_SEQ_TIMEOUT_EN.
- With the macro defined:
  - A per-phase counter clears on entry to ENC/DEC and increments each waiting cycle.
  - On reaching TIMEOUT_CYCLES without dp_done → DONE with op_error=1, DATA_OUT=0, NUM_OF_ERRORS=00.
- Without the macro: no counter; the FSM waits indefinitely for dp_done.

Decomposition:
- Package ecc_pkg holds:
  - mode codes (MODE_ENC=2'b00, MODE_DEC=2'b01, MODE_FULL=2'b10)
  - width codes and the width→mask function
  - FSM state encoding
  - error-count codes
- One natural sub-module, ecc_noise_mask: combinational width decode and masked XOR, used in NOISE_ADD.
- FSM and counter stay in the top module.

Test Plan:
- Encode: CTRL=0, width=00, DATA_IN=0xA5, ctrl_wr.
  - Model dp_done after 1 cycle with result 0x1A5.
  - Expect one dp_start, dp_mode=0, DATA_OUT=0x1A5, NUM_OF_ERRORS=0, operation_done at cycle 3.
- Full channel: CTRL=2, width=01, DATA_IN=0x1234, NOISE=0xFFFF0004.
  - Expect decode-phase dp_data = encoded value ^ 0x0004.
  - Expect two dp_start pulses, NUM_OF_ERRORS=01, operation_done at cycle 6.
- Illegal request: CTRL=3 → no dp_start; op_error=1, operation_done=1, busy stays 0.
- Busy protection: ctrl_wr with different DATA_IN during DEC → dp_data unchanged; no second operation.
- Reset mid-operation: rst=0 during ENC, then a late dp_done → state IDLE; all outputs 0; dp_done ignored.
- ECC_SEQ_TIMEOUT_EN with TIMEOUT_CYCLES=16 and dp_done never asserted → op_error=1, operation_done=1 after 16 wait cycles.
